// File: rtl/dataproc_sched.sv
// rtl/dataproc_sched.sv - iomem-mapped job sequencer feeding the byte-stream data processor
module dataproc_sched #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LEN_W      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        dp_in_valid,
    input  logic        dp_in_ready,
    output logic [7:0]  dp_in_data,
    input  logic        dp_out_valid,
    output logic        dp_out_ready,
    input  logic [7:0]  dp_out_data,
    output logic [1:0]  dp_mode,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [7:0]       in_mem  [FIFO_DEPTH];
    logic [7:0]       out_mem [FIFO_DEPTH];
    logic [AW-1:0]    in_wp, in_rp, out_wp, out_rp;
    logic [CW-1:0]    in_cnt, out_cnt;
    logic [LEN_W-1:0] len, sent, recv;
    logic [1:0]       mode_reg;
    logic             irq_en, done, err;

    logic       hit, acc, wr, rd;
    logic [2:0] offs;
    logic       wr_ctrl, start_req, abort_req, wr_len, wr_stat, wr_in, rd_out, wr_irqen;
    logic       in_full, in_empty, out_full, out_empty, busy;
    logic       in_push, in_pop, out_push, out_pop;
    logic [31:0] rd_val;
    logic       unused_bits;

    // A new access is only taken while ready is low, which also forces the idle gap after each ack.
    assign hit  = (iomem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc  = iomem_valid && hit && !iomem_ready;
    assign wr   = acc && (|iomem_wstrb);
    assign rd   = acc && (iomem_wstrb == 4'b0000);
    assign offs = iomem_addr[4:2];

    assign wr_ctrl   = wr && (offs == 3'd0);
    assign abort_req = wr_ctrl && iomem_wdata[1];
    assign start_req = wr_ctrl && iomem_wdata[0] && !iomem_wdata[1];
    assign wr_len    = wr && (offs == 3'd1);
    assign wr_stat   = wr && (offs == 3'd2);
    assign wr_in     = wr && (offs == 3'd3);
    assign rd_out    = rd && (offs == 3'd4);
    assign wr_irqen  = wr && (offs == 3'd5);

    assign in_full   = (in_cnt == CW'(FIFO_DEPTH));
    assign in_empty  = (in_cnt == '0);
    assign out_full  = (out_cnt == CW'(FIFO_DEPTH));
    assign out_empty = (out_cnt == '0);
    assign busy      = (state != S_IDLE);

    assign dp_in_valid  = (state == S_RUN) && !in_empty;
    assign dp_in_data   = dp_in_valid ? in_mem[in_rp] : 8'h00;
    assign dp_out_ready = ((state == S_RUN) || (state == S_DRAIN)) && !out_full && (recv < len);

    assign in_push  = wr_in && !in_full;
    assign in_pop   = dp_in_valid && dp_in_ready;
    assign out_push = dp_out_valid && dp_out_ready;
    assign out_pop  = rd_out && !out_empty;

    assign irq         = done && irq_en;
    assign unused_bits = &{1'b0, iomem_addr[1:0], iomem_wdata};

    always_comb begin
        rd_val = 32'h0;
        case (offs)
            3'd0: rd_val = {28'h0, mode_reg, 2'b00};
            3'd1: rd_val = 32'(len);
            3'd2: rd_val = {16'h0, 8'(out_cnt), 3'b000, err, out_empty, in_full, done, busy};
            3'd4: rd_val = out_empty ? 32'h0 : {24'h0, out_mem[out_rp]};
            3'd5: rd_val = {31'h0, irq_en};
            default: rd_val = 32'h0;
        endcase
    end

    // Storage carries no reset; stale entries are never visible outside the pointers.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wp]   <= iomem_wdata[7:0];
        if (out_push) out_mem[out_wp] <= dp_out_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            in_wp <= '0; in_rp <= '0; in_cnt <= '0;
            out_wp <= '0; out_rp <= '0; out_cnt <= '0;
            len <= '0; sent <= '0; recv <= '0;
            mode_reg <= 2'b00;
            dp_mode  <= 2'b00;
            irq_en <= 1'b0; done <= 1'b0; err <= 1'b0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= rd ? rd_val : 32'h0;
            if (wr_irqen) irq_en <= iomem_wdata[0];
            if (wr_ctrl) mode_reg <= iomem_wdata[3:2];
            if (wr_len && !busy) len <= iomem_wdata[LEN_W-1:0];
            if (wr_stat && iomem_wdata[1]) done <= 1'b0;
            if (wr_stat && iomem_wdata[4]) err <= 1'b0;
            if ((wr_in && in_full) || (rd_out && out_empty) || (start_req && busy)) err <= 1'b1;

            if (in_push)  in_wp  <= in_wp + AW'(1);
            if (in_pop)   in_rp  <= in_rp + AW'(1);
            if (out_push) out_wp <= out_wp + AW'(1);
            if (out_pop)  out_rp <= out_rp + AW'(1);
            in_cnt  <= in_cnt + CW'(in_push) - CW'(in_pop);
            out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
            if (in_pop)   sent <= sent + LEN_W'(1);
            if (out_push) recv <= recv + LEN_W'(1);

            case (state)
                S_IDLE: if (start_req) begin
                    if (len != '0) begin
                        dp_mode <= iomem_wdata[3:2];
                        sent    <= '0;
                        recv    <= '0;
                        state   <= S_RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                S_RUN:   if (in_pop && ((sent + LEN_W'(1)) == len)) state <= S_DRAIN;
                S_DRAIN: if (recv == len) state <= S_DONE;
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Abort overrides everything above, including a start in the same write.
            if (abort_req) begin
                state <= S_IDLE;
                in_wp <= '0; in_rp <= '0; in_cnt <= '0;
                out_wp <= '0; out_rp <= '0; out_cnt <= '0;
                sent <= '0; recv <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dataproc_sched.sv
// tb/tb_dataproc_sched.sv - self-checking bench for dataproc_sched
module tb_dataproc_sched;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        dp_in_valid;
    logic        dp_in_ready = 1'b0;
    logic [7:0]  dp_in_data;
    logic        dp_out_valid = 1'b0;
    logic        dp_out_ready;
    logic [7:0]  dp_out_data = 8'h0;
    logic [1:0]  dp_mode;
    logic        irq;

    dataproc_sched dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready), .dp_in_data(dp_in_data),
        .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready), .dp_out_data(dp_out_data),
        .dp_mode(dp_mode), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: input FIFO contents, expected results in order, output FIFO occupancy, job bookkeeping.
    logic [7:0]  in_q[$];
    logic [7:0]  exp_res[$];
    logic [7:0]  pend[$];
    int          out_n = 0;
    int          job_len = 0, job_sent = 0, job_recv = 0, hs_in = 0;
    int          rdy_mode = 0;
    logic [15:0] m_len = 16'h0;
    logic [1:0]  m_mode = 2'b00;
    logic        rd_pend = 1'b0, prev_rdy = 1'b0, tog = 1'b0;
    logic [31:0] rd_exp = 32'h0;
    logic [31:0] sd, d;
    int          pushed, got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rdv);
        logic ack;
        ack = 1'b0;
        rdv = 32'h0;
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'(off);
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int i = 0; i < 20 && !ack; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                ack = 1'b1;
                rdv = iomem_rdata;
            end
        end
        chk("bus_ack", {31'h0, ack}, 32'h1);
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(off, 4'hF, wd, dummy);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] rdv);
        bus(off, 4'h0, 32'h0, rdv);
    endtask

    task automatic wait_done();
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < 100 && !s[1]; i++) rd(8'h08, s);
        chk("done_seen", {31'h0, s[1]}, 32'h1);
    endtask

    // Datapath stand-in: result = input ^ 0xFF, in order, with selectable input backpressure.
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (rdy_mode)
            0: dp_in_ready = 1'b0;
            1: dp_in_ready = 1'b1;
            2: dp_in_ready = tog;
            default: dp_in_ready = (hs_in < 2);
        endcase
        if (pend.size() > 0) begin
            dp_out_valid = 1'b1;
            dp_out_data  = pend[0];
        end else begin
            dp_out_valid = 1'b0;
            dp_out_data  = 8'h00;
        end
    end

    // Compare process: bus events are applied before datapath events so FIFO full/empty use start-of-cycle occupancy.
    always @(negedge clk) begin
        logic [2:0] off;
        logic       abort_now;
        if (!resetn) begin
            in_q.delete(); exp_res.delete(); pend.delete();
            out_n = 0; job_len = 0; job_sent = 0; job_recv = 0; hs_in = 0;
            m_len = 16'h0; m_mode = 2'b00; rd_pend = 1'b0; prev_rdy = 1'b0;
        end else begin
            abort_now = 1'b0;
            if (prev_rdy) chk("ready_gap", {31'h0, iomem_ready}, 32'h0);
            if (!iomem_ready) chk("rdata_idle", iomem_rdata, 32'h0);
            if (iomem_ready && rd_pend) begin
                chk("out_data", iomem_rdata, rd_exp);
                rd_pend = 1'b0;
            end
            prev_rdy = iomem_ready;
            if (iomem_valid && !iomem_ready && (iomem_addr[31:5] == BASE[31:5])) begin
                off = iomem_addr[4:2];
                if (iomem_wstrb != 4'h0) begin
                    if (off == 3'd0 && iomem_wdata[1]) begin
                        abort_now = 1'b1;
                        in_q.delete(); exp_res.delete(); pend.delete();
                        out_n = 0; job_len = 0; job_sent = 0; job_recv = 0;
                    end else if (off == 3'd0 && iomem_wdata[0] && job_recv >= job_len && m_len != 16'h0) begin
                        m_mode = iomem_wdata[3:2];
                        job_len = int'(m_len); job_sent = 0; job_recv = 0; hs_in = 0;
                    end else if (off == 3'd1 && job_recv >= job_len) begin
                        m_len = iomem_wdata[15:0];
                    end else if (off == 3'd3 && in_q.size() < DEPTH) begin
                        in_q.push_back(iomem_wdata[7:0]);
                    end
                end else if (off == 3'd4) begin
                    rd_pend = 1'b1;
                    if (out_n > 0) begin
                        rd_exp = {24'h0, exp_res.pop_front()};
                        out_n--;
                    end else begin
                        rd_exp = 32'h0;
                    end
                end
            end
            if (!abort_now) begin
                if (dp_in_valid) chk("in_nonempty", {31'h0, in_q.size() != 0}, 32'h1);
                if (dp_in_valid && dp_in_ready && in_q.size() != 0) begin
                    chk("dp_in_data", {24'h0, dp_in_data}, {24'h0, in_q[0]});
                    chk("dp_mode_in", {30'h0, dp_mode}, {30'h0, m_mode});
                    job_sent++;
                    chk("sent_le_len", {31'h0, job_sent <= job_len}, 32'h1);
                    exp_res.push_back(in_q.pop_front() ^ 8'hFF);
                    pend.push_back(dp_in_data ^ 8'hFF);
                    hs_in++;
                end
                if (dp_out_valid && dp_out_ready) begin
                    chk("dp_mode_out", {30'h0, dp_mode}, {30'h0, m_mode});
                    job_recv++;
                    chk("recv_le_len", {31'h0, job_recv <= job_len}, 32'h1);
                    out_n++;
                    if (pend.size() > 0) void'(pend.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_dp", {28'h0, dp_in_valid, dp_out_ready, dp_mode}, 32'h0);
        chk("rst_irq_data", {23'h0, irq, dp_in_data}, 32'h0);
        resetn = 1'b1;
        rd(8'h08, sd); chk("rst_status", sd, 32'h08);
        rd(8'h04, sd); chk("rst_len", sd, 32'h0);
        rd(8'h00, sd); chk("rst_ctrl", sd, 32'h0);

        // Basic job
        rdy_mode = 1;
        wr(8'h14, 32'h1);
        wr(8'h0C, 32'h11); wr(8'h0C, 32'h22); wr(8'h0C, 32'h33);
        wr(8'h04, 32'd3);
        wr(8'h00, 32'h09);
        rd(8'h08, sd); chk("basic_busy", {31'h0, sd[0]}, 32'h1);
        wait_done();
        rd(8'h08, sd); chk("basic_status", sd, 32'h0302);
        chk("basic_mode", {30'h0, dp_mode}, 32'h2);
        chk("basic_irq", {31'h0, irq}, 32'h1);
        rd(8'h10, d); chk("basic_out0", d, 32'hEE);
        rd(8'h10, d); chk("basic_out1", d, 32'hDD);
        rd(8'h10, d); chk("basic_out2", d, 32'hCC);
        rd(8'h08, sd); chk("basic_empty", sd, 32'h0A);
        wr(8'h08, 32'h02);
        chk("basic_irq_clr", {31'h0, irq}, 32'h0);

        // Error flags
        for (int i = 0; i < 5; i++) wr(8'h0C, 32'hA0 + i);
        rd(8'h08, sd); chk("err_full", sd, 32'h1C);
        rd(8'h10, d); chk("err_empty_rd", d, 32'h0);
        wr(8'h08, 32'h10);
        rd(8'h08, sd); chk("err_clr", sd, 32'h0C);
        wr(8'h04, 32'd4);
        wr(8'h00, 32'h05);
        wait_done();
        rd(8'h10, d); chk("err_job_out0", d, 32'h5F);
        for (int i = 0; i < 3; i++) rd(8'h10, d);
        chk("err_job_last", d, 32'h5C);
        wr(8'h08, 32'h02);

        // LEN=0 and start while busy
        wr(8'h04, 32'd0);
        wr(8'h00, 32'h01);
        rd(8'h08, sd); chk("len0_status", sd, 32'h0A);
        wr(8'h08, 32'h02);
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) wr(8'h0C, 32'hB0 + i);
        wr(8'h04, 32'd4);
        wr(8'h00, 32'h0D);
        wr(8'h00, 32'h05);
        rd(8'h08, sd); chk("busy_restart", sd, 32'h1D);
        rdy_mode = 1;
        wait_done();
        rd(8'h08, sd); chk("busy_done", sd, 32'h0412);
        chk("busy_mode", {30'h0, dp_mode}, 32'h3);
        for (int i = 0; i < 4; i++) rd(8'h10, d);
        chk("busy_last", d, 32'h4C);
        wr(8'h08, 32'h12);
        rd(8'h08, sd); chk("busy_clr", sd, 32'h08);

        // Abort mid-job
        for (int i = 0; i < 4; i++) wr(8'h0C, 32'hC0 + i);
        wr(8'h04, 32'd4);
        rdy_mode = 3;
        wr(8'h00, 32'h01);
        repeat (10) @(posedge clk);
        rd(8'h08, sd); chk("abort_pre", sd, 32'h0201);
        wr(8'h00, 32'h02);
        chk("abort_dp", {30'h0, dp_in_valid, dp_out_ready}, 32'h0);
        rd(8'h08, sd); chk("abort_status", sd, 32'h08);
        rdy_mode = 1;
        wr(8'h0C, 32'hD0); wr(8'h0C, 32'hD1);
        wr(8'h04, 32'd2);
        wr(8'h00, 32'h01);
        wait_done();
        rd(8'h10, d); chk("abort_new0", d, 32'h2F);
        rd(8'h10, d); chk("abort_new1", d, 32'h2E);
        wr(8'h08, 32'h02);

        // Backpressure: LEN=8 through 4-deep FIFOs
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) wr(8'h0C, 32'hE0 + i);
        pushed = 4;
        got = 0;
        wr(8'h04, 32'd8);
        wr(8'h00, 32'h01);
        for (int it = 0; it < 300 && got < 8; it++) begin
            rd(8'h08, sd);
            if (pushed < 8 && !sd[2]) begin
                wr(8'h0C, 32'hE0 + pushed);
                pushed++;
            end
            if (sd[15:8] != 8'h0) begin
                rd(8'h10, d);
                if (got == 0) chk("bp_first", d, 32'h1F);
                got++;
            end
        end
        chk("bp_count", got, 8);
        wait_done();
        rd(8'h08, sd); chk("bp_status", sd, 32'h0A);
        wr(8'h08, 32'h02);
        repeat (5) @(posedge clk);
        rd(8'h08, sd); chk("bp_once", sd, 32'h08);

        // Out-of-window access
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h20; iomem_wstrb = 4'h0;
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (iomem_ready) got++;
        end
        chk("oow_no_ready", got, 0);
        @(posedge clk); #1;
        iomem_valid = 1'b0;

        // Asynchronous reset mid-RUN
        rdy_mode = 0;
        wr(8'h0C, 32'hF0); wr(8'h0C, 32'hF1);
        wr(8'h04, 32'd4);
        wr(8'h00, 32'h0D);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_run", {29'h0, dp_in_valid, dp_mode}, 32'h7);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("arst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("arst_rdata", iomem_rdata, 32'h0);
        chk("arst_dp", {28'h0, dp_in_valid, dp_out_ready, dp_mode}, 32'h0);
        chk("arst_irq_data", {23'h0, irq, dp_in_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        rd(8'h08, sd); chk("arst_status", sd, 32'h08);
        rd(8'h04, sd); chk("arst_len", sd, 32'h0);
        rd(8'h14, sd); chk("arst_irqen", sd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
